pc_gen_unit: RTL



---
 rtl/pc_gen_pkg.sv | 22 ++
 rtl/pc_gen_unit_target_calc.sv | 28 ++
 rtl/pc_gen_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the program-counter generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SEL_TRAP     = 3'd0,
    SEL_MRET     = 3'd1,
    SEL_MISALIGN = 3'd2,
    SEL_TARGET   = 3'd3,
    SEL_HOLD     = 3'd4,
    SEL_STEP     = 3'd5
  } next_sel_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_gen_unit_target_calc.sv
// Combinational target/link arithmetic: branch or JALR target, pc+STEP and
// misalignment detection of the target. All sums wrap modulo 2^XLEN.
module pc_target_calc #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  input  logic            i_mode,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_step,
  output logic            o_misalign
);

  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_sum;

  assign w_base = i_mode ? i_rs1 : i_pc;
  assign w_sum  = w_base + i_imm;

  // JALR clears bit 0 of the sum; PC-relative targets are taken as is.
  assign o_target = i_mode ? {w_sum[XLEN-1:1], 1'b0} : w_sum;
  assign o_step   = i_pc + XLEN'(STEP);

  assign o_misalign = (STEP == 2) ? o_target[0] : (|o_target[1:0]);

endmodule

// File: rtl/pc_gen_unit.sv
// Registered PC generator: BOOT/RUN/HALT state machine and the PC register,
// selecting the next PC with trap > mret > redirect > hold > step priority.
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              STEP      = 4,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            if_ready_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic            redirect_mode_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            trap_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_step_o,
  output logic [XLEN-1:0] pc_target_o,
  output logic            misalign_o
);

  state_e          r_state;
  state_e          w_nextState;
  next_sel_e       w_sel;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_nextPc;
  logic            r_misalign;
  logic            w_targetMisalign;

  pc_target_calc #(
    .XLEN(XLEN),
    .STEP(STEP)
  ) u_target_calc (
    .i_pc      (r_pc),
    .i_imm     (imm_i),
    .i_rs1     (rs1_i),
    .i_mode    (redirect_mode_i),
    .o_target  (pc_target_o),
    .o_step    (pc_step_o),
    .o_misalign(w_targetMisalign)
  );

  always_comb begin
    w_nextState = r_state;
    w_sel       = SEL_HOLD;
    unique case (r_state)
      ST_BOOT: w_nextState = ST_RUN;
      ST_RUN: begin
        // Halting freezes the PC on the instruction it was asserted with.
        if (halt_i && !trap_i && !redirect_i) w_nextState = ST_HALT;
        if (trap_i)                          w_sel = SEL_TRAP;
        else if (mret_i)                     w_sel = SEL_MRET;
        else if (redirect_i)                 w_sel = w_targetMisalign ? SEL_MISALIGN : SEL_TARGET;
        else if (halt_i)                     w_sel = SEL_HOLD;
        else if (stall_i || !if_ready_i)     w_sel = SEL_HOLD;
        else                                 w_sel = SEL_STEP;
      end
      ST_HALT: begin
        if (trap_i) begin
          w_nextState = ST_RUN;
          w_sel       = SEL_TRAP;
        end else if (resume_i) begin
          w_nextState = ST_RUN;
        end
      end
      default: w_nextState = ST_BOOT;
    endcase
  end

  always_comb begin
    w_nextPc = r_pc;
    unique case (w_sel)
      SEL_TRAP, SEL_MISALIGN: w_nextPc = TRAP_VEC;
      SEL_MRET:               w_nextPc = epc_i;
      SEL_TARGET:             w_nextPc = pc_target_o;
      SEL_STEP:               w_nextPc = pc_step_o;
      default:                w_nextPc = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_BOOT;
      r_pc       <= RESET_VEC;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_pc       <= w_nextPc;
      r_misalign <= (w_sel == SEL_MISALIGN);
    end
  end

  assign pc_o       = r_pc;
  assign pc_valid_o = (r_state == ST_RUN);
  assign misalign_o = r_misalign;

endmodule
